// File: rtl/memcache_pkg.sv
// Shared widths, FSM encoding and the eviction-queue entry type for the
// store-cache write-side controller.
package memcache_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;
endpackage

// File: rtl/memcache_evq.sv
// Eviction FIFO: register-array storage with registered head, wrapping
// pointers and an explicit occupancy count.
module memcache_evq
  import memcache_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data
);
  ent_t            mem_q [DEPTH];
  ent_t            mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (AW+1)'(DEPTH));
    do_pop  = pop & ~empty;
    // A full queue only takes a new entry when the head leaves in the same cycle.
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    if (do_push) mem_d[wr_ptr_q] = '{addr: push_addr, data: push_data};
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    count     = count_q;
    head_addr = mem_q[rd_ptr_q].addr;
    head_data = mem_q[rd_ptr_q].data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/memcache_ctrl.sv
// Store-cache write-side controller: round-robin arbitration of two store
// sources, eviction buffering toward memory, and an eviction-drain fence.
module memcache_ctrl
  import memcache_pkg::*;
#(
  parameter int EVQ_DEPTH = 4,
  parameter int EVQ_AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [14:0]       req0_addr,
  input  logic [15:0]       req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [14:0]       req1_addr,
  input  logic [15:0]       req1_data,
  output logic              cache_wen,
  output logic [14:0]       cache_waddr,
  output logic [15:0]       cache_wdata,
  input  logic              evict_wen,
  input  logic [14:0]       evict_addr,
  input  logic [15:0]       evict_data,
  output logic              mem_wvalid,
  input  logic              mem_wready,
  output logic [14:0]       mem_waddr,
  output logic [15:0]       mem_wdata,
  input  logic              fence_req,
  output logic              fence_done,
  output logic [EVQ_AW:0]   evq_count
);
  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   gnt0, gnt1, pop, push, can_accept;
  logic   evq_full, evq_empty;

  memcache_evq #(.DEPTH(EVQ_DEPTH), .AW(EVQ_AW)) u_evq (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_addr (evict_addr),
    .push_data (evict_data),
    .pop       (pop),
    .full      (evq_full),
    .empty     (evq_empty),
    .count     (evq_count),
    .head_addr (mem_waddr),
    .head_data (mem_wdata)
  );

  always_comb begin
    mem_wvalid = ~rst & ~evq_empty;
    pop        = mem_wvalid & mem_wready;
    // Every accepted store may evict, so reserve a slot before granting.
    can_accept = ~evq_full | pop;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst && state_q == ST_IDLE && can_accept) begin
      if (req0_valid && req1_valid) begin
        if (last_grant_q) gnt0 = 1'b1;
        else              gnt1 = 1'b1;
      end else if (req0_valid) begin
        gnt0 = 1'b1;
      end else if (req1_valid) begin
        gnt1 = 1'b1;
      end
    end
    last_grant_d = gnt0 ? 1'b0 : (gnt1 ? 1'b1 : last_grant_q);
    req0_ready  = gnt0;
    req1_ready  = gnt1;
    cache_wen   = gnt0 | gnt1;
    cache_waddr = gnt1 ? req1_addr : req0_addr;
    cache_wdata = gnt1 ? req1_data : req0_data;
    push        = evict_wen & cache_wen;

    state_d    = state_q;
    fence_done = 1'b0;
    case (state_q)
      ST_IDLE:  if (fence_req) state_d = ST_DRAIN;
      ST_DRAIN: if (evq_empty || (evq_count == (EVQ_AW+1)'(1) && pop)) state_d = ST_DONE;
      ST_DONE: begin
        fence_done = ~rst;
        state_d    = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // The cache only evicts as a side effect of a write we issued.
  a_evict_needs_grant: assert property (@(posedge clk) disable iff (rst) evict_wen |-> cache_wen);
endmodule

// File: tb/tb_memcache_ctrl.sv
// Bench for memcache_ctrl: vector table plus hand sequences; evictions
// are tracked in a scoreboard queue and checked at the memory port.
module tb_memcache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [14:0] req0_addr, req1_addr, cache_waddr, evict_addr, mem_waddr;
  logic [15:0] req0_data, req1_data, cache_wdata, evict_data, mem_wdata;
  logic        cache_wen, evict_wen, mem_wvalid, mem_wready, fence_req, fence_done;
  logic [2:0]  evq_count;
  logic        ev_en;

  int n_chk = 0;
  int n_fail = 0;
  int ev_ctr = 1;

  typedef struct packed {
    logic [14:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    string nm;
    logic  r0v, r1v, ev, mrdy, fr, rs;
    logic  e0, e1;
    int    ecnt;
    logic  emv, edone;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  // Cache model: it evicts only alongside a write it receives.
  assign evict_wen = cache_wen & ev_en;

  memcache_ctrl #(.EVQ_DEPTH(4), .EVQ_AW(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
    .cache_wen(cache_wen), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
    .evict_wen(evict_wen), .evict_addr(evict_addr), .evict_data(evict_data),
    .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .fence_req(fence_req), .fence_done(fence_done), .evq_count(evq_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    rst        = v.rs;
    req0_valid = v.r0v;
    req1_valid = v.r1v;
    ev_en      = v.ev;
    mem_wready = v.mrdy;
    fence_req  = v.fr;
    evict_addr = 15'(ev_ctr);
    evict_data = 16'hE000 + 16'(ev_ctr);
    #1;
    chk({v.nm, " req0_ready"}, 32'(req0_ready), 32'(v.e0));
    chk({v.nm, " req1_ready"}, 32'(req1_ready), 32'(v.e1));
    chk({v.nm, " cache_wen"},  32'(cache_wen),  32'(v.e0 | v.e1));
    chk({v.nm, " evq_count"},  32'(evq_count),  32'(v.ecnt));
    chk({v.nm, " mem_wvalid"}, 32'(mem_wvalid), 32'(v.emv));
    chk({v.nm, " fence_done"}, 32'(fence_done), 32'(v.edone));
    if (v.e0 | v.e1) begin
      chk({v.nm, " cache_waddr"}, 32'(cache_waddr), 32'(v.e1 ? req1_addr : req0_addr));
      chk({v.nm, " cache_wdata"}, 32'(cache_wdata), 32'(v.e1 ? req1_data : req0_data));
    end
    if (mem_wvalid) begin
      if (sb.size() == 0) begin
        chk({v.nm, " unexpected mem_wvalid"}, 32'(mem_wvalid), 32'd0);
      end else begin
        chk({v.nm, " mem_waddr"}, 32'(mem_waddr), 32'(sb[0].addr));
        chk({v.nm, " mem_wdata"}, 32'(mem_wdata), 32'(sb[0].data));
      end
    end
    if (v.rs) begin
      sb.delete();
    end else begin
      if (mem_wvalid && v.mrdy && sb.size() > 0) void'(sb.pop_front());
      if (v.ev && (v.e0 | v.e1)) begin
        e.addr = evict_addr;
        e.data = evict_data;
        sb.push_back(e);
        ev_ctr++;
      end
    end
  endtask

  task automatic s(input string nm, input logic r0v, r1v, ev, mrdy, fr, rs,
                   input logic e0, e1, input int ecnt, input logic emv, edone);
    vec_t v;
    v = '{nm, r0v, r1v, ev, mrdy, fr, rs, e0, e1, ecnt, emv, edone};
    step(v);
  endtask

  initial begin
    rst = 1'b1; req0_valid = 0; req1_valid = 0; ev_en = 0; mem_wready = 0; fence_req = 0;
    req0_addr = 15'h0010; req0_data = 16'hBEEF;
    req1_addr = 15'h0020; req1_data = 16'hCAFE;
    evict_addr = '0; evict_data = '0;
    repeat (2) @(posedge clk);

    //            nm           r0 r1 ev mr fr rs  e0 e1 cnt mv dn
    tbl.push_back('{"rst_force", 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{"cont0",     1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{"cont1",     1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{"cont2",     1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{"cont3",     1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{"single",    1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{"ev1",       1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0});
    tbl.push_back('{"ev2",       1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0});
    tbl.push_back('{"ev3",       1, 0, 1, 0, 0, 0, 1, 0, 2, 1, 0});
    tbl.push_back('{"hold_a",    0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0});
    tbl.push_back('{"hold_b",    0, 0, 0, 0, 0, 0, 0, 0, 3, 1, 0});
    tbl.push_back('{"drain1",    0, 0, 0, 1, 0, 0, 0, 0, 3, 1, 0});
    tbl.push_back('{"drain2",    0, 0, 0, 1, 0, 0, 0, 0, 2, 1, 0});
    tbl.push_back('{"drain3",    0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0});
    tbl.push_back('{"drained",   0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{"fill1",     0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{"fill2",     0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0});
    tbl.push_back('{"fill3",     0, 1, 1, 0, 0, 0, 0, 1, 2, 1, 0});
    tbl.push_back('{"fill4",     0, 1, 1, 0, 0, 0, 0, 1, 3, 1, 0});
    tbl.push_back('{"full_a",    0, 1, 1, 0, 0, 0, 0, 0, 4, 1, 0});
    tbl.push_back('{"full_b",    0, 1, 1, 0, 0, 0, 0, 0, 4, 1, 0});
    tbl.push_back('{"full_pop",  0, 1, 1, 1, 0, 0, 0, 1, 4, 1, 0});
    tbl.push_back('{"full_hold", 0, 0, 0, 0, 0, 0, 0, 0, 4, 1, 0});
    tbl.push_back('{"fdrain1",   0, 0, 0, 1, 0, 0, 0, 0, 4, 1, 0});
    tbl.push_back('{"fdrain2",   0, 0, 0, 1, 0, 0, 0, 0, 3, 1, 0});
    tbl.push_back('{"fdrain3",   0, 0, 0, 1, 0, 0, 0, 0, 2, 1, 0});
    tbl.push_back('{"fdrain4",   0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0});
    tbl.push_back('{"fdrained",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    foreach (tbl[i]) step(tbl[i]);

    // Fence with two queued evictions; a grant is still legal on the entry cycle.
    s("fn_fill1", 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    s("fn_fill2", 1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0);
    s("fn_go",    1, 1, 0, 1, 1, 0, 0, 1, 2, 1, 0);
    s("fn_drain", 1, 1, 0, 1, 1, 0, 0, 0, 1, 1, 0);
    s("fn_done",  1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1);
    s("fn_post",  1, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0);

    // Fence on an empty queue completes two cycles after the request.
    s("fe_req",   0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    s("fe_drain", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    s("fe_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    s("fe_idle",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset with evictions still queued.
    s("rm_fill1", 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    s("rm_fill2", 1, 0, 1, 0, 0, 0, 1, 0, 1, 1, 0);
    s("rm_fill3", 1, 0, 1, 0, 0, 0, 1, 0, 2, 1, 0);
    s("rm_rst",   1, 1, 0, 1, 0, 1, 0, 0, 3, 0, 0);
    s("rm_tie0",  1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    s("rm_tie1",  1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/memcache_ctrl.md
Name: memcache_ctrl

Overview:
- Write-side controller for the store cache (LEN-entry shift cache, single write port, eviction output).
- Arbitrates two store requesters onto the cache write port with round-robin fairness.
- Buffers evicted entries in a small FIFO and drains them to data memory over a valid/ready write port.
- Provides a fence that blocks new stores until all evictions have reached memory.

Parameters:
EVQ_DEPTH, 4, eviction FIFO depth in entries (power of two, >= 2)
EVQ_AW, 2, FIFO pointer width, log2(EVQ_DEPTH)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 (pipeline store stage) has a store
req0_ready  output  1  requester 0 store accepted this cycle
req0_addr  input  15  word address [15:1]
req0_data  input  16  store data
req1_valid  input  1  requester 1 (secondary store source) has a store
req1_ready  output  1  requester 1 store accepted this cycle
req1_addr  input  15  word address [15:1]
req1_data  input  16  store data
cache_wen  output  1  cache write enable
cache_waddr  output  15  cache write address
cache_wdata  output  16  cache write data
evict_wen  input  1  cache eviction strobe, same cycle as cache_wen
evict_addr  input  15  evicted address
evict_data  input  16  evicted data
mem_wvalid  output  1  FIFO head valid toward memory
mem_wready  input  1  memory accepts head this cycle
mem_waddr  output  15  FIFO head address
mem_wdata  output  16  FIFO head data
fence_req  input  1  level request to drain evictions
fence_done  output  1  one-cycle pulse when fence completes
evq_count  output  EVQ_AW+1  current FIFO occupancy

Behaviour:
- Reset (rst high at an edge): FIFO empty, pointers 0, evq_count 0, last_grant = 1 (req0 wins first tie), state IDLE. While rst is high, the combinational outputs cache_wen, req*_ready, mem_wvalid and fence_done are forced 0. Reset mid-drain discards queued evictions.
- pop = mem_wvalid & mem_wready. mem_wvalid = (count != 0). Head address/data come from registers; they are held stable while valid and not ready.
- can_accept = (count < EVQ_DEPTH) | pop. This is conservative: every accepted store may evict.
- Grant: only in IDLE with can_accept. If exactly one requester is valid, it is granted. If both are valid, grant the one not equal to last_grant, then update last_grant. No grant leaves last_grant unchanged.
- A grant drives cache_wen = 1 with the winner's addr/data and asserts that requester's ready, all in the same cycle (zero latency). Requesters hold valid/addr/data until ready.
- Push: evict_wen is sampled in the same cycle. It pushes evict_addr/data at the tail at the edge.
- Simultaneous push and pop: count unchanged, both pointers advance. Push while full can only occur with a same-cycle pop. An evict_wen arriving with no grant is a protocol error; flag it by simulation assertion only.
- Pointers wrap modulo EVQ_DEPTH. count saturates at EVQ_DEPTH by construction.
- State machine:
  - IDLE -> DRAIN when fence_req = 1. Grants are still allowed on the transition cycle.
  - DRAIN: no grants. When count == 0, or count == 1 with pop, go to DONE.
  - DONE: fence_done = 1 for exactly one cycle, then IDLE. If fence_req is still high in IDLE, a new fence starts immediately.
  - Fence with an empty FIFO: IDLE -> DRAIN -> DONE, so fence_done appears 2 cycles after fence_req.
- Memory draining continues in every state.

Decomposition:
- Shared package: ADDR_W = 15, DATA_W = 16, and the state encodings IDLE/DRAIN/DONE.
- One natural sub-module: memcache_evq, a synchronous FIFO (push, pop, full, empty, count, head).
- Arbiter and FSM stay in the top module.

Test Plan:
- Single store: req0_valid, addr 0x0010, data 0xBEEF, no evict -> req0_ready and cache_wen same cycle, cache_waddr 0x0010, count stays 0.
- Contention: both valid for 4 cycles after reset -> grants in order req0, req1, req0, req1.
- Eviction flow: 3 grants each with evict_wen (addrs 0x1,0x2,0x3), mem_wready low -> count 3, mem_waddr 0x1 held. Then raise mem_wready -> drains 0x1,0x2,0x3 in order, count 0.
- Full backpressure with EVQ_DEPTH 4 and mem_wready low:
  - 4 evicting stores -> count 4, then req*_ready = 0.
  - Pulse mem_wready -> pop, and the store is accepted that same cycle.
- Fence: count 2, fence_req high, mem_wready high -> no grants while in DRAIN, fence_done a single pulse after the last pop.
- Reset mid-operation: count 3, assert rst one cycle -> count 0, mem_wvalid 0, next tie goes to req0.
